load_wb_sequencer: RTL and testbench

- Sequences the register-file write port for the writeback stage when data memory has variable read latency.
- Non-load results (ALU, LUI/AUIPC, JAL/JALR link) pass straight to the register file.
- For a load, the block issues a word read, stalls the pipeline until the response arrives, then writes one register. Before the write it lane-aligns the read data and sign- or zero-extends it per funct3.
- Sits between the writeback-stage decode and the register file / data-memory read port.

---
 rtl/load_wb_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_load_wb_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_wb_sequencer.sv
// Writeback-stage register-file write sequencer.
// Non-load results pass straight through to the register file. A load issues a
// word read, stalls the pipeline until the response arrives or times out, then
// performs a single lane-aligned, sign/zero-extended register write.
module load_wb_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        w_valid,
  input  logic [6:0]  w_opcode,
  input  logic [2:0]  w_funct3,
  input  logic [4:0]  w_rd,
  input  logic        w_we,
  input  logic [31:0] w_data,
  input  logic [31:0] w_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        err_timeout,
  output logic        err_misalign
);

  localparam logic [6:0]       OPC_LOAD   = 7'b0000011;
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_timeout_q, err_timeout_d;

  logic              is_load;
  logic              illegal;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ext_data;

  assign is_load = w_valid && (w_opcode == OPC_LOAD);

  // Illegal load: reserved funct3, or address not aligned to the access size.
  always_comb begin
    illegal = 1'b0;
    case (w_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = w_addr[0];
      3'b010:         illegal = |w_addr[1:0];
      default:        illegal = 1'b1;
    endcase
  end

  // Lane-align the captured word and extend it according to funct3.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_sel = data_q[7:0];
      2'd1:    byte_sel = data_q[15:8];
      2'd2:    byte_sel = data_q[23:16];
      default: byte_sel = data_q[31:24];
    endcase
    half_sel = addr_q[1] ? data_q[31:16] : data_q[15:0];
    ext_data = 32'h0;
    case (funct3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext_data = data_q;
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = 32'h0;
    endcase
  end

  // Next-state and capture logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    data_d        = data_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          rd_d     = w_rd;
          funct3_d = w_funct3;
          addr_d   = w_addr;
          if (illegal) begin
            data_d  = 32'h0;
            state_d = S_WB;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d = '0;
          if (mem_rsp_valid) begin
            data_d  = mem_rsp_data;
            state_d = S_WB;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = S_WB;
        end else if (cnt_q == CNT_EXPIRE) begin
          data_d        = 32'h0;
          err_timeout_d = 1'b1;
          state_d       = S_WB;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_q          <= 5'd0;
      funct3_q      <= 3'd0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Output decode; the IDLE pass-through is held at zero while in reset.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'h0;
    stall         = 1'b0;
    rf_we         = 1'b0;
    rf_rd         = 5'd0;
    rf_wdata      = 32'h0;
    err_misalign  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!reset) begin
          if (is_load) begin
            stall        = 1'b1;
            err_misalign = illegal;
          end else if (w_valid) begin
            rf_we    = w_we && (w_rd != 5'd0);
            rf_rd    = w_rd;
            rf_wdata = w_data;
          end
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[31:2], 2'b00};
        stall         = 1'b1;
      end
      S_WAIT: begin
        stall = 1'b1;
      end
      default: begin
        rf_we    = (rd_q != 5'd0);
        rf_rd    = rd_q;
        rf_wdata = ext_data;
      end
    endcase
  end

  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_load_wb_sequencer.sv
// Directed bench for load_wb_sequencer with a register-write scoreboard.
module tb_load_wb_sequencer;

  localparam int unsigned TO       = 4;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;
  localparam logic [6:0]  OPC_ALU  = 7'b0110011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        w_valid;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_we;
  logic [31:0] w_data;
  logic [31:0] w_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        err_timeout;
  logic        err_misalign;

  int vectors     = 0;
  int miscompares = 0;
  wr_t exp_q[$];

  load_wb_sequencer #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .w_valid       (w_valid),
    .w_opcode      (w_opcode),
    .w_funct3      (w_funct3),
    .w_rd          (w_rd),
    .w_we          (w_we),
    .w_data        (w_data),
    .w_addr        (w_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .stall         (stall),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .err_timeout   (err_timeout),
    .err_misalign  (err_misalign)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_in();
    w_valid  = 1'b0;
    w_opcode = 7'd0;
    w_funct3 = 3'd0;
    w_rd     = 5'd0;
    w_we     = 1'b0;
    w_data   = 32'h0;
    w_addr   = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    w_valid  = 1'b1;
    w_opcode = OPC_LOAD;
    w_funct3 = f3;
    w_rd     = rd;
    w_we     = 1'b0;
    w_data   = 32'h0;
    w_addr   = addr;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    w_valid  = 1'b1;
    w_opcode = OPC_ALU;
    w_funct3 = 3'd0;
    w_rd     = rd;
    w_we     = 1'b1;
    w_data   = data;
    w_addr   = 32'h0;
  endtask

  // Load whose request is accepted and answered in the same REQ cycle.
  task automatic load_fast(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
    drive_load(f3, rd, addr);
    if (rd != 5'd0) exp_q.push_back('{rd: rd, data: exp_data});
    sample();
    check("fast_idle_stall", stall, 1);
    step();
    idle_in();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    sample();
    check("fast_req_addr", mem_req_addr, {addr[31:2], 2'b00});
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    sample();
    check("fast_wb_stall", stall, 0);
    check("fast_wb_we", rf_we, (rd != 5'd0));
    step();
  endtask

  // Scoreboard: every register write must match the oldest pending expectation.
  always @(negedge clock) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rf_unexpected_we", rf_we, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("rf_rd", rf_rd, e.rd);
        check("rf_wdata", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    idle_in();
    repeat (2) @(posedge clock);
    sample();
    check("reset_outputs",
          {stall, rf_we, mem_req_valid, err_timeout, err_misalign, rf_rd, rf_wdata, mem_req_addr}, 0);
    step();
    reset = 1'b0;

    // Non-load pass-through, then rd=0 suppression.
    drive_alu(5'd5, 32'h1234);
    exp_q.push_back('{rd: 5'd5, data: 32'h1234});
    sample();
    check("nl_stall", stall, 0);
    check("nl_we", rf_we, 1);
    step();
    w_rd = 5'd0;
    sample();
    check("nl_rd0_we", rf_we, 0);
    step();
    idle_in();

    // LB at 0x103, response two cycles after acceptance.
    drive_load(3'b000, 5'd7, 32'h103);
    exp_q.push_back('{rd: 5'd7, data: 32'hFFFF_FF80});
    sample();
    check("lb_idle_stall", stall, 1);
    check("lb_idle_we", rf_we, 0);
    check("lb_idle_req", mem_req_valid, 0);
    step();
    idle_in();
    mem_req_ready = 1'b1;
    sample();
    check("lb_req_valid", mem_req_valid, 1);
    check("lb_req_addr", mem_req_addr, 32'h100);
    check("lb_req_stall", stall, 1);
    step();
    mem_req_ready = 1'b0;
    sample();
    check("lb_wait1_stall", stall, 1);
    check("lb_wait1_req", mem_req_valid, 0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FF_0000;
    sample();
    check("lb_wait2_stall", stall, 1);
    step();
    mem_rsp_valid = 1'b0;
    sample();
    check("lb_wb_stall", stall, 0);
    check("lb_wb_we", rf_we, 1);
    step();

    // LHU at 0x202 with three cycles of back-pressure.
    drive_load(3'b101, 5'd9, 32'h202);
    exp_q.push_back('{rd: 5'd9, data: 32'h0000_BEEF});
    sample();
    check("lhu_idle_stall", stall, 1);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("lhu_bp_valid", mem_req_valid, 1);
      check("lhu_bp_addr", mem_req_addr, 32'h200);
      step();
    end
    mem_req_ready = 1'b1;
    sample();
    check("lhu_req_valid", mem_req_valid, 1);
    check("lhu_req_addr", mem_req_addr, 32'h200);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBEEF_0001;
    sample();
    check("lhu_wait_stall", stall, 1);
    step();
    mem_rsp_valid = 1'b0;
    sample();
    check("lhu_wb_stall", stall, 0);
    step();

    // Misaligned LW: no request, error pulse, write of zero.
    drive_load(3'b010, 5'd3, 32'h301);
    exp_q.push_back('{rd: 5'd3, data: 32'h0});
    sample();
    check("mis_pulse", err_misalign, 1);
    check("mis_no_req", mem_req_valid, 0);
    check("mis_stall", stall, 1);
    step();
    idle_in();
    sample();
    check("mis_wb_stall", stall, 0);
    check("mis_wb_pulse_end", err_misalign, 0);
    check("mis_wb_no_req", mem_req_valid, 0);
    check("mis_wb_we", rf_we, 1);
    step();

    // Reserved funct3 is treated as illegal.
    drive_load(3'b011, 5'd13, 32'h0);
    exp_q.push_back('{rd: 5'd13, data: 32'h0});
    sample();
    check("f3_illegal_pulse", err_misalign, 1);
    step();
    idle_in();
    sample();
    check("f3_illegal_we", rf_we, 1);
    step();

    // Same-cycle ready+response loads, then a non-load right after WB.
    load_fast(3'b100, 5'd10, 32'h701, 32'h1234_ABCD, 32'h0000_00AB);
    drive_alu(5'd11, 32'h55);
    exp_q.push_back('{rd: 5'd11, data: 32'h55});
    sample();
    check("post_wb_nl_we", rf_we, 1);
    step();
    idle_in();
    load_fast(3'b001, 5'd12, 32'h802, 32'h8001_7777, 32'hFFFF_8001);
    load_fast(3'b010, 5'd0, 32'h900, 32'h1111_2222, 32'h0);

    // Response in the expiry cycle wins over the timeout.
    drive_load(3'b010, 5'd6, 32'h500);
    exp_q.push_back('{rd: 5'd6, data: 32'hCAFE_F00D});
    sample();
    step();
    idle_in();
    mem_req_ready = 1'b1;
    sample();
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("exp_wait_stall", stall, 1);
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    sample();
    check("exp_last_wait_stall", stall, 1);
    step();
    mem_rsp_valid = 1'b0;
    sample();
    check("exp_wb_no_timeout", err_timeout, 0);
    check("exp_wb_stall", stall, 0);
    step();
    sample();
    check("exp_idle_no_timeout", err_timeout, 0);
    step();

    // No response: timeout after TO wait cycles, sticky error.
    drive_load(3'b010, 5'd4, 32'h400);
    exp_q.push_back('{rd: 5'd4, data: 32'h0});
    sample();
    step();
    idle_in();
    mem_req_ready = 1'b1;
    sample();
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      sample();
      check("to_wait_stall", stall, 1);
      check("to_wait_err", err_timeout, 0);
      step();
    end
    sample();
    check("to_wb_err", err_timeout, 1);
    check("to_wb_stall", stall, 0);
    check("to_wb_we", rf_we, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("to_sticky", err_timeout, 1);
      step();
    end

    // Reset during WAIT drops the load; a late response is ignored.
    drive_load(3'b010, 5'd8, 32'h600);
    sample();
    step();
    idle_in();
    mem_req_ready = 1'b1;
    sample();
    step();
    mem_req_ready = 1'b0;
    sample();
    check("rst_wait_stall", stall, 1);
    #1;
    reset = 1'b1;
    step();
    sample();
    check("rst_outputs",
          {stall, rf_we, mem_req_valid, err_timeout, err_misalign, rf_rd, rf_wdata, mem_req_addr}, 0);
    step();
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    sample();
    check("rst_late_rsp_we", rf_we, 0);
    check("rst_late_rsp_stall", stall, 0);
    check("rst_late_rsp_req", mem_req_valid, 0);
    step();
    mem_rsp_valid = 1'b0;
    sample();
    check("rst_after_we", rf_we, 0);
    step();

    check("sb_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
